// File: rtl/thor2024_pkg.sv
// Shared types for the flow-control tracker: FSM state encoding and the
// per-entry record kept for each outstanding branch/jump.
package thor2024_pkg;

   localparam int FC_PC_W = 32;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RECOVER = 2'd2
   } fc_state_t;

   typedef struct packed {
      logic               valid;
      logic               done;
      logic               pred;
      logic               taken;
      logic [FC_PC_W-1:0] pc;
   } fc_entry_t;

endpackage

// File: rtl/thor2024_fc_tracker.sv
// Circular tracker of outstanding flow-control instructions: allocates at
// decode, resolves out of order, retires in order, redirects on mispredict.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_EMPTY   | no outstanding entries
// ST_BUSY    | one or more outstanding entries
// ST_RECOVER | one cycle after a mispredict; allocation held off, rd_v high
module thor2024_fc_tracker
   import thor2024_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter int  AW    = 32,
   localparam int TW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          dec_v,
   input  logic          dec_fc,
   input  logic [AW-1:0] dec_pc,
   input  logic          dec_pred,
   output logic          dec_rdy,
   output logic [TW-1:0] dec_tag,
   input  logic          rs_v,
   input  logic [TW-1:0] rs_tag,
   input  logic          rs_taken,
   input  logic [AW-1:0] rs_npc,
   output logic          rd_v,
   output logic [AW-1:0] rd_pc,
   output logic          cm_v,
   output logic [AW-1:0] cm_pc,
   output logic          cm_taken,
   input  logic          cm_rdy,
   output logic [TW:0]   cnt
);

   fc_entry_t     ent_q [DEPTH];
   fc_entry_t     ent_n [DEPTH];
   logic [TW-1:0] head_q, head_n;
   logic [TW-1:0] tail_q, tail_n;
   logic [TW:0]   cnt_q, cnt_n;
   fc_state_t     state_q, state_n;
   logic          live_q;
   logic          rd_v_q;
   logic [AW-1:0] rd_pc_q;

   logic          rs_ok;
   logic          mispredict;
   logic          full;
   logic          alloc;
   logic          retire;
   logic [TW-1:0] rs_off;

   assign rs_ok      = rs_v & ent_q[rs_tag].valid & ~ent_q[rs_tag].done;
   assign mispredict = rs_ok & (rs_taken != ent_q[rs_tag].pred);
   assign full       = (cnt_q == (TW+1)'(DEPTH));
   // live_q holds ready low until the first edge after reset release
   assign dec_rdy    = live_q & (state_q != ST_RECOVER) & ~full & ~mispredict;
   assign alloc      = dec_v & dec_fc & dec_rdy;
   assign cm_v       = ent_q[head_q].valid & ent_q[head_q].done;
   assign retire     = cm_v & cm_rdy;
   assign rs_off     = rs_tag - head_q;

   assign dec_tag  = tail_q;
   assign cm_pc    = AW'(ent_q[head_q].pc);
   assign cm_taken = ent_q[head_q].taken;
   assign rd_v     = rd_v_q;
   assign rd_pc    = rd_pc_q;
   assign cnt      = cnt_q;

   always_comb begin
      ent_n  = ent_q;
      head_n = head_q;
      tail_n = tail_q;
      cnt_n  = cnt_q;

      if (retire) begin
         ent_n[head_q].valid = 1'b0;
         ent_n[head_q].done  = 1'b0;
         head_n              = head_q + 1'b1;
      end

      if (rs_ok) begin
         ent_n[rs_tag].done  = 1'b1;
         ent_n[rs_tag].taken = rs_taken;
      end

      if (mispredict) begin
         // age is measured as ring distance from head; anything past rs_tag is wrong-path
         for (int i = 0; i < DEPTH; i++) begin
            if (TW'(TW'(i) - head_q) > rs_off) begin
               ent_n[i].valid = 1'b0;
               ent_n[i].done  = 1'b0;
            end
         end
         tail_n = rs_tag + 1'b1;
         cnt_n  = {1'b0, rs_off} + (TW+1)'(1) - (TW+1)'(retire);
      end else begin
         if (alloc) begin
            ent_n[tail_q].valid = 1'b1;
            ent_n[tail_q].done  = 1'b0;
            ent_n[tail_q].pred  = dec_pred;
            ent_n[tail_q].taken = 1'b0;
            ent_n[tail_q].pc    = FC_PC_W'(dec_pc);
            tail_n              = tail_q + 1'b1;
         end
         cnt_n = cnt_q + (TW+1)'(alloc) - (TW+1)'(retire);
      end

      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_n[i] = '0;
         end
         head_n = '0;
         tail_n = '0;
         cnt_n  = '0;
      end
   end

   always_comb begin
      state_n = state_q;
      if (flush) begin
         state_n = ST_EMPTY;
      end else if (mispredict) begin
         state_n = ST_RECOVER;
      end else if (cnt_n == '0) begin
         state_n = ST_EMPTY;
      end else begin
         state_n = ST_BUSY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         live_q  <= 1'b0;
         rd_v_q  <= 1'b0;
         rd_pc_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_n[i];
         end
         head_q <= head_n;
         tail_q <= tail_n;
         cnt_q  <= cnt_n;
         live_q <= 1'b1;
         rd_v_q <= mispredict & ~flush;
         if (mispredict & ~flush) begin
            rd_pc_q <= rs_npc;
         end
      end
   end

endmodule

// File: tb/tb_thor2024_fc_tracker.sv
// Bench for the flow-control tracker: directed scenarios plus a randomized
// run checked against an ordered-queue model of the outstanding entries.
module tb_thor2024_fc_tracker;

   localparam int D  = 4;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush, dec_v, dec_fc, dec_pred, rs_v, rs_taken, cm_rdy;
   logic [AW-1:0] dec_pc, rs_npc;
   logic [1:0]    rs_tag;
   logic          dec_rdy, rd_v, cm_v, cm_taken;
   logic [1:0]    dec_tag;
   logic [AW-1:0] rd_pc, cm_pc;
   logic [2:0]    cnt;

   int checks = 0;
   int errors = 0;

   thor2024_fc_tracker #(.DEPTH(D), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .dec_v(dec_v), .dec_fc(dec_fc), .dec_pc(dec_pc), .dec_pred(dec_pred),
      .dec_rdy(dec_rdy), .dec_tag(dec_tag),
      .rs_v(rs_v), .rs_tag(rs_tag), .rs_taken(rs_taken), .rs_npc(rs_npc),
      .rd_v(rd_v), .rd_pc(rd_pc),
      .cm_v(cm_v), .cm_pc(cm_pc), .cm_taken(cm_taken), .cm_rdy(cm_rdy),
      .cnt(cnt)
   );

   always #5 clk = ~clk;

   task automatic idle();
      flush = 0; dec_v = 0; dec_fc = 0; dec_pc = '0; dec_pred = 0;
      rs_v = 0; rs_tag = '0; rs_taken = 0; rs_npc = '0; cm_rdy = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic alloc(input logic [AW-1:0] pc, input logic pred);
      dec_v = 1; dec_fc = 1; dec_pc = pc; dec_pred = pred;
      tick();
      dec_v = 0; dec_fc = 0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      tick();
      tick();
      checks++; if (dec_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %0h want 0", dec_rdy); end
      checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
      checks++; if (cm_v !== 1'b0) begin errors++; $display("FAIL reset_cmv got %0h want 0", cm_v); end
      checks++; if (rd_v !== 1'b0) begin errors++; $display("FAIL reset_rdv got %0h want 0", rd_v); end
      checks++; if (rd_pc !== '0) begin errors++; $display("FAIL reset_rdpc got %0h want 0", rd_pc); end
      rst_n = 1;
      tick();
      checks++; if (dec_rdy !== 1'b1) begin errors++; $display("FAIL release_rdy got %0h want 1", dec_rdy); end
      checks++; if (dec_tag !== 2'd0) begin errors++; $display("FAIL release_tag got %0d want 0", dec_tag); end
   endtask

   task automatic test_fill();
      logic [AW-1:0] pc;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         pc = 32'h100 + 32'(5 * i);
         dec_v = 1; dec_fc = 1; dec_pc = pc; dec_pred = 0;
         #1;
         checks++; if (dec_tag !== 2'(i)) begin errors++; $display("FAIL fill_tag got %0d want %0d", dec_tag, i); end
         checks++; if (dec_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy got %0h want 1", dec_rdy); end
         tick();
      end
      dec_v = 1; dec_fc = 1; dec_pc = 32'h114;
      #1;
      checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL fill_cnt got %0d want 4", cnt); end
      checks++; if (dec_rdy !== 1'b0) begin errors++; $display("FAIL fill_fifth_rdy got %0h want 0", dec_rdy); end
      idle();
   endtask

   task automatic test_inorder_retire();
      do_reset();
      for (int i = 0; i < 4; i++) alloc(32'h100 + 32'(5 * i), 1'b0);
      cm_rdy = 1;
      rs_v = 1; rs_tag = 2; rs_taken = 0;
      tick();
      checks++; if (cm_v !== 1'b0) begin errors++; $display("FAIL ooo_cmv got %0h want 0", cm_v); end
      rs_tag = 0;
      tick();
      rs_v = 0;
      checks++; if (cm_v !== 1'b1) begin errors++; $display("FAIL head_cmv got %0h want 1", cm_v); end
      checks++; if (cm_pc !== 32'h100) begin errors++; $display("FAIL head_cmpc got %0h want 100", cm_pc); end
      tick();
      checks++; if (cm_v !== 1'b0) begin errors++; $display("FAIL wait_t1_cmv got %0h want 0", cm_v); end
      checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL retire_cnt got %0d want 3", cnt); end
      rs_v = 1; rs_tag = 1; rs_taken = 0;
      tick();
      rs_v = 0;
      checks++; if (cm_pc !== 32'h105 || cm_v !== 1'b1) begin errors++; $display("FAIL t1_cm got v=%0h pc=%0h want v=1 pc=105", cm_v, cm_pc); end
      tick();
      checks++; if (cm_pc !== 32'h10A || cm_v !== 1'b1) begin errors++; $display("FAIL t2_cm got v=%0h pc=%0h want v=1 pc=10a", cm_v, cm_pc); end
      tick();
      checks++; if (cm_v !== 1'b0 || cnt !== 3'd1) begin errors++; $display("FAIL drain got v=%0h cnt=%0d want v=0 cnt=1", cm_v, cnt); end
      idle();
   endtask

   task automatic test_mispredict();
      do_reset();
      for (int i = 0; i < 4; i++) alloc(32'h100 + 32'(5 * i), 1'b0);
      rs_v = 1; rs_tag = 1; rs_taken = 1; rs_npc = 32'h200;
      #1;
      checks++; if (dec_rdy !== 1'b0) begin errors++; $display("FAIL mp_comb_rdy got %0h want 0", dec_rdy); end
      tick();
      idle();
      checks++; if (rd_v !== 1'b1 || rd_pc !== 32'h200) begin errors++; $display("FAIL mp_redirect got v=%0h pc=%0h want v=1 pc=200", rd_v, rd_pc); end
      checks++; if (cnt !== 3'd2 || dec_tag !== 2'd2) begin errors++; $display("FAIL mp_trim got cnt=%0d tail=%0d want cnt=2 tail=2", cnt, dec_tag); end
      checks++; if (dec_rdy !== 1'b0) begin errors++; $display("FAIL mp_recover_rdy got %0h want 0", dec_rdy); end
      tick();
      checks++; if (rd_v !== 1'b0 || dec_rdy !== 1'b1) begin errors++; $display("FAIL mp_after got rdv=%0h rdy=%0h want rdv=0 rdy=1", rd_v, dec_rdy); end
      rs_v = 1; rs_tag = 2; rs_taken = 1; rs_npc = 32'h300;
      #1;
      checks++; if (dec_rdy !== 1'b1) begin errors++; $display("FAIL stale_rdy got %0h want 1", dec_rdy); end
      tick();
      idle();
      checks++; if (rd_v !== 1'b0) begin errors++; $display("FAIL stale_rdv got %0h want 0", rd_v); end
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < 4; i++) alloc(32'h100 + 32'(5 * i), 1'b0);
      rs_v = 1; rs_tag = 0; rs_taken = 0;
      tick();
      rs_v = 0;
      cm_rdy = 1; dec_v = 1; dec_fc = 1; dec_pc = 32'h300; dec_pred = 1;
      #1;
      checks++; if (dec_rdy !== 1'b0 || cnt !== 3'd4) begin errors++; $display("FAIL full_nobypass got rdy=%0h cnt=%0d want rdy=0 cnt=4", dec_rdy, cnt); end
      tick();
      checks++; if (cnt !== 3'd3 || dec_rdy !== 1'b1 || dec_tag !== 2'd0) begin errors++; $display("FAIL full_retire got cnt=%0d rdy=%0h tag=%0d want 3 1 0", cnt, dec_rdy, dec_tag); end
      tick();
      checks++; if (cnt !== 3'd4 || dec_tag !== 2'd1) begin errors++; $display("FAIL wrap_alloc got cnt=%0d tag=%0d want 4 1", cnt, dec_tag); end
      idle();
   endtask

   task automatic test_flush_mp();
      do_reset();
      for (int i = 0; i < 4; i++) alloc(32'h100 + 32'(5 * i), 1'b0);
      flush = 1; rs_v = 1; rs_tag = 1; rs_taken = 1; rs_npc = 32'h400;
      tick();
      idle();
      checks++; if (cnt !== 3'd0 || rd_v !== 1'b0) begin errors++; $display("FAIL flush_mp got cnt=%0d rdv=%0h want 0 0", cnt, rd_v); end
      checks++; if (dec_rdy !== 1'b1 || dec_tag !== 2'd0) begin errors++; $display("FAIL flush_ptr got rdy=%0h tag=%0d want 1 0", dec_rdy, dec_tag); end
      tick();
      checks++; if (rd_v !== 1'b0) begin errors++; $display("FAIL flush_late_rdv got %0h want 0", rd_v); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) alloc(32'h500 + 32'(4 * i), 1'b0);
      rs_v = 1; rs_tag = 0; rs_taken = 1; rs_npc = 32'h600;
      #2;
      rst_n = 0;
      #1;
      checks++; if (cnt !== 3'd0 || dec_rdy !== 1'b0 || cm_v !== 1'b0) begin errors++; $display("FAIL midrst_imm got cnt=%0d rdy=%0h cmv=%0h want 0 0 0", cnt, dec_rdy, cm_v); end
      checks++; if (rd_v !== 1'b0 || rd_pc !== '0) begin errors++; $display("FAIL midrst_rd got v=%0h pc=%0h want 0 0", rd_v, rd_pc); end
      idle();
      tick();
      tick();
      rst_n = 1;
      tick();
      checks++; if (dec_rdy !== 1'b1 || cnt !== 3'd0 || rd_v !== 1'b0) begin errors++; $display("FAIL midrst_rel got rdy=%0h cnt=%0d rdv=%0h want 1 0 0", dec_rdy, cnt, rd_v); end
   endtask

   task automatic test_random();
      int            q[$];
      logic          m_pred [D];
      logic          m_done [D];
      logic          m_taken[D];
      logic [AW-1:0] m_pc   [D];
      int            next_tag, idx, tg;
      logic          m_rd, m_recover, ok, mp, e_cmv, e_rdy, ret, alc;
      logic [AW-1:0] m_rdpc;
      do_reset();
      next_tag = 0; m_rd = 0; m_recover = 0; m_rdpc = '0;
      for (int i = 0; i < D; i++) begin
         m_pred[i] = 0; m_done[i] = 0; m_taken[i] = 0; m_pc[i] = '0;
      end
      for (int c = 0; c < 600; c++) begin
         flush    = ($urandom_range(0, 49) == 0);
         dec_v    = 1'($urandom_range(0, 1));
         dec_fc   = ($urandom_range(0, 3) != 0);
         dec_pc   = $urandom;
         dec_pred = 1'($urandom_range(0, 1));
         rs_v     = 1'($urandom_range(0, 1));
         if (q.size() > 0 && $urandom_range(0, 3) != 0)
            rs_tag = 2'(q[$urandom_range(0, q.size() - 1)]);
         else
            rs_tag = 2'($urandom_range(0, D - 1));
         rs_taken = 1'($urandom_range(0, 1));
         rs_npc   = $urandom;
         cm_rdy   = ($urandom_range(0, 3) != 0);
         #1;
         tg  = int'(rs_tag);
         idx = -1;
         foreach (q[k]) if (q[k] == tg) idx = k;
         ok    = rs_v && (idx >= 0) && !m_done[tg];
         mp    = ok && (rs_taken != m_pred[tg]);
         e_cmv = (q.size() > 0) && m_done[q[0]];
         e_rdy = !m_recover && (q.size() < D) && !mp;
         checks++; if (dec_rdy !== e_rdy) begin errors++; $display("FAIL rnd_rdy c=%0d got %0h want %0h", c, dec_rdy, e_rdy); end
         checks++; if (dec_tag !== 2'(next_tag)) begin errors++; $display("FAIL rnd_tag c=%0d got %0d want %0d", c, dec_tag, next_tag); end
         checks++; if (cnt !== 3'(q.size())) begin errors++; $display("FAIL rnd_cnt c=%0d got %0d want %0d", c, cnt, q.size()); end
         checks++; if (cm_v !== e_cmv) begin errors++; $display("FAIL rnd_cmv c=%0d got %0h want %0h", c, cm_v, e_cmv); end
         if (e_cmv) begin
            checks++; if (cm_pc !== m_pc[q[0]] || cm_taken !== m_taken[q[0]]) begin errors++; $display("FAIL rnd_cm c=%0d got pc=%0h tk=%0h want pc=%0h tk=%0h", c, cm_pc, cm_taken, m_pc[q[0]], m_taken[q[0]]); end
         end
         checks++; if (rd_v !== m_rd) begin errors++; $display("FAIL rnd_rdv c=%0d got %0h want %0h", c, rd_v, m_rd); end
         if (m_rd) begin
            checks++; if (rd_pc !== m_rdpc) begin errors++; $display("FAIL rnd_rdpc c=%0d got %0h want %0h", c, rd_pc, m_rdpc); end
         end
         if (flush) begin
            q.delete();
            next_tag = 0; m_rd = 0; m_recover = 0;
         end else begin
            ret = e_cmv && cm_rdy;
            alc = dec_v && dec_fc && e_rdy;
            if (ok) begin
               m_done[tg] = 1; m_taken[tg] = rs_taken;
            end
            if (mp) begin
               while (q.size() > idx + 1) void'(q.pop_back());
               next_tag = (tg + 1) % D;
               m_rdpc = rs_npc;
            end
            if (ret) void'(q.pop_front());
            if (alc) begin
               q.push_back(next_tag);
               m_pred[next_tag] = dec_pred; m_done[next_tag] = 0; m_pc[next_tag] = dec_pc;
               next_tag = (next_tag + 1) % D;
            end
            m_rd = mp; m_recover = mp;
         end
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_fill();
      test_inorder_retire();
      test_mispredict();
      test_full_wrap();
      test_flush_mp();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
